// File: rtl/poly_voice_allocator_if.sv
// Note-event handshake and per-voice output bus between the MIDI front end and the voice bank.
interface poly_voice_allocator_if #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_WIDTH = 7,
  parameter int unsigned VEL_WIDTH  = 7
);
  logic                             evt_valid;
  logic                             evt_ready;
  logic                             evt_note_on;
  logic [NOTE_WIDTH-1:0]            evt_note;
  logic [VEL_WIDTH-1:0]             evt_vel;
  logic [NUM_VOICES-1:0]            voice_active;
  logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note;
  logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_vel;
  logic [NUM_VOICES-1:0]            voice_trig;
  logic                             steal;

  // Event source / voice-bank side
  modport master (
    output evt_valid, evt_note_on, evt_note, evt_vel,
    input  evt_ready, voice_active, voice_note, voice_vel, voice_trig, steal
  );

  // Allocator side
  modport slave (
    input  evt_valid, evt_note_on, evt_note, evt_vel,
    output evt_ready, voice_active, voice_note, voice_vel, voice_trig, steal
  );
endinterface

// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: sequential scan of voice slots, then a single commit
// choosing retrigger > free slot > steal-oldest for note-on, or release for note-off.
module poly_voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_WIDTH = 7,
  parameter int unsigned VEL_WIDTH  = 7,
  parameter int unsigned AGE_WIDTH  = 8
) (
  input logic                   clk_in,
  input logic                   rst_in,
  poly_voice_allocator_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state_q, state_next;
  logic   ready_q;

  logic                  ev_on_q;
  logic [NOTE_WIDTH-1:0] ev_note_q;
  logic [VEL_WIDTH-1:0]  ev_vel_q;
  logic [IDX_W-1:0]      idx_q;

  logic                  match_found_q, free_found_q, old_found_q;
  logic [IDX_W-1:0]      match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_WIDTH-1:0]  old_age_q;

  logic [NUM_VOICES-1:0] active_q;
  logic [NOTE_WIDTH-1:0] note_q [NUM_VOICES];
  logic [VEL_WIDTH-1:0]  vel_q  [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  age_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] trig_q;
  logic                  steal_q;

  logic                  hs_c;
  logic [IDX_W-1:0]      target_c;
  logic                  steal_c;

  assign hs_c = bus.evt_valid && ready_q;

  // State register; ready is registered alongside it so it is high exactly in IDLE
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_next;
      ready_q <= (state_next == IDLE);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (hs_c) state_next = SCAN;
      SCAN:    if (idx_q == IDX_W'(NUM_VOICES - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Note-on target choice from the scan results
  always_comb begin
    target_c = old_idx_q;
    steal_c  = 1'b0;
    if (match_found_q)     target_c = match_idx_q;
    else if (free_found_q) target_c = free_idx_q;
    else                   steal_c  = 1'b1;
  end

  // Event latch, scan candidates and per-voice state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      old_found_q   <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      active_q      <= '0;
      trig_q        <= '0;
      steal_q       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      trig_q  <= '0;
      steal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs_c) begin
            // velocity 0 on a note-on is a note-off
            ev_on_q       <= bus.evt_note_on && (bus.evt_vel != '0);
            ev_note_q     <= bus.evt_note;
            ev_vel_q      <= bus.evt_vel;
            idx_q         <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            old_found_q   <= 1'b0;
          end
        end
        SCAN: begin
          if (active_q[idx_q]) begin
            if (!match_found_q && (note_q[idx_q] == ev_note_q)) begin
              match_found_q <= 1'b1;
              match_idx_q   <= idx_q;
            end
            // strict compare keeps the lowest index on equal ages
            if (!old_found_q || (age_q[idx_q] > old_age_q)) begin
              old_found_q <= 1'b1;
              old_idx_q   <= idx_q;
              old_age_q   <= age_q[idx_q];
            end
          end else if (!free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
          end
          idx_q <= idx_q + IDX_W'(1);
        end
        COMMIT: begin
          if (ev_on_q) begin
            steal_q <= steal_c;
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IDX_W'(i) == target_c) begin
                active_q[i] <= 1'b1;
                note_q[i]   <= ev_note_q;
                vel_q[i]    <= ev_vel_q;
                age_q[i]    <= '0;
                trig_q[i]   <= 1'b1;
              end else if (active_q[i] && (age_q[i] != '1)) begin
                age_q[i] <= age_q[i] + AGE_WIDTH'(1);
              end
            end
          end else if (match_found_q) begin
            active_q[match_idx_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.evt_ready    = ready_q;
  assign bus.voice_active = active_q;
  assign bus.voice_trig   = trig_q;
  assign bus.steal        = steal_q;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign bus.voice_note[g*NOTE_WIDTH +: NOTE_WIDTH] = note_q[g];
    assign bus.voice_vel[g*VEL_WIDTH +: VEL_WIDTH]    = vel_q[g];
  end
endmodule

// File: doc/poly_voice_allocator.md
Name: poly_voice_allocator

Overview:
- Parametrised polyphonic successor to the single-voice MIDI note path.
- Sits between midi_processor note events and a bank of NUM_VOICES oscillators.
- Assigns note-on events to free voice slots, releases slots on note-off, and steals the oldest voice when all slots are busy.
- Drives per-voice active/note/velocity registers and one-cycle retrigger pulses.

Parameters:
NUM_VOICES, 8, number of voice slots (2..32)
NOTE_WIDTH, 7, MIDI note number width
VEL_WIDTH, 7, MIDI velocity width
AGE_WIDTH, 8, per-voice saturating age counter width

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  reset, asynchronous, active-high
evt_valid_in  input  1  note event valid
evt_ready_out  output  1  allocator can accept an event
evt_note_on_in  input  1  1 = note-on, 0 = note-off
evt_note_in  input  NOTE_WIDTH  MIDI note number
evt_vel_in  input  VEL_WIDTH  velocity
voice_active_out  output  NUM_VOICES  per-voice gate
voice_note_out  output  NUM_VOICES*NOTE_WIDTH  per-voice note; voice i at bits [i*NOTE_WIDTH +: NOTE_WIDTH]
voice_vel_out  output  NUM_VOICES*VEL_WIDTH  per-voice velocity, packed the same way
voice_trig_out  output  NUM_VOICES  one-cycle pulse when a voice is (re)assigned
steal_out  output  1  one-cycle pulse when an active voice was stolen

Behaviour:
- Reset (async assert): FSM=IDLE; all voice_*_out, ages, steal_out and the latched event = 0; evt_ready_out = 1 after deassert.
- Reset mid-scan drops the pending event.
- Note-on with velocity 0 is treated as note-off.
- FSM states IDLE -> SCAN -> COMMIT -> IDLE.
- IDLE: evt_ready_out = 1. A handshake (valid & ready at a clock edge) latches note_on/note/vel and moves to SCAN with idx = 0.
- SCAN: evt_ready_out = 0. Examine voice idx once per cycle for idx = 0..NUM_VOICES-1, then go to COMMIT. Scan registers track three candidates:
  - match: the first active voice whose note equals the latched note.
  - free: the first inactive voice.
  - oldest: the active voice with the largest age; ties go to the lowest index.
- COMMIT, single cycle. Target selection priority for note-on: match (retrigger) > free > oldest (steal). At the edge ending COMMIT:
  - Target: active=1, note and vel loaded, age=0, trig pulses high for exactly the next cycle.
  - Every other active voice: age += 1, saturating at all-ones.
  - steal_out pulses only when oldest was chosen.
- Note-off, match found: that voice gets active=0; its note and vel are held; no trig; ages unchanged.
- Note-off, no match: no state change, no pulses.
- Latency: event accepted at edge E0 -> outputs and pulses update at edge E0+NUM_VOICES+1. evt_ready_out reasserts at the same edge. Maximum throughput is one event per NUM_VOICES+2 cycles.
- Inactive voices keep their last note/vel (release tails); their age is frozen.
- Exactly one trig bit is high at a time; trig and steal are never asserted outside the cycle after COMMIT.
- evt_* inputs are ignored while evt_ready_out = 0; upstream must hold valid until the handshake.

Test Plan (NUM_VOICES=4):
1. Reset, then note-on 60/vel 100 -> at edge E0+5: active=0001, voice0 note=60 vel=100, trig=0001 for 1 cycle, ready back high.
2. Note-on 60, 62, 64, 65 in sequence -> active=1111, notes 60/62/64/65 in voices 0..3, ages 3/2/1/0, steal_out never pulses.
3. From scenario 2, note-on 67 -> voice0 (oldest, age 3) gets note 67, trig=0001, steal_out pulses once, active stays 1111.
4. Note-on 62 vel 30 while 62 is active in voice1 -> retrigger voice1: vel=30, age=0, trig=0010, no steal, no second voice gets 62.
5. Note-off 64, then note-on 64 vel 0, then note-off 99 (absent):
   - First event frees the voice holding 64; the vel-0 note-on is a no-op (64 already released); note-off 99 changes nothing and pulses nothing.
   - Next note-on 70 lands in that freed lowest-index voice.
6. Assert rst_in mid-SCAN after accepting note-on 72 -> outputs clear immediately (async); after release, active=0000 and note 72 is never assigned; ready=1 on the first cycle out of reset.
